// File: rtl/dcache_ctrl.sv
// Miss-handling and write-through sequencer for a 2-way set-associative data cache.
// Refills one line per read miss (invalid-first, then LRU victim) and forwards every store to memory.
module dcache_ctrl #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int SET_BITS   = 4,
  parameter int WORD_BITS  = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  read_en,
  input  logic                  write_en,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] write_data,
  input  logic                  hit,
  input  logic                  hit_way,
  input  logic [1:0]            way_valid,
  output logic                  stall,
  output logic                  cache_wr_en,
  output logic                  refill_en,
  output logic                  refill_way,
  output logic [WORD_BITS-1:0]  refill_word,
  output logic [DATA_WIDTH-1:0] refill_data,
  output logic                  refill_last,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic                  mem_ack,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic [31:0]           hit_count,
  output logic [31:0]           miss_count
);

  localparam int OFF_BITS = 2 + WORD_BITS;
  localparam int NUM_SETS = 1 << SET_BITS;
  localparam logic [ADDR_WIDTH-1:0] LINE_MASK = ADDR_WIDTH'((1 << OFF_BITS) - 1);
  localparam logic [ADDR_WIDTH-1:0] BYTE_MASK = ADDR_WIDTH'(3);
  localparam logic [WORD_BITS-1:0]  LAST_BEAT = '1;

  typedef enum logic [1:0] {IDLE, REFILL, WRITE} state_e;

  state_e                state_q, state_d;
  logic [WORD_BITS-1:0]  beat_q, beat_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
  logic                  victim_q, victim_d;
  logic [NUM_SETS-1:0]   lru_q, lru_d;
  logic [31:0]           hit_count_q, hit_count_d;
  logic [31:0]           miss_count_q, miss_count_d;

  logic [SET_BITS-1:0]   cpu_set;
  logic [SET_BITS-1:0]   refill_set;
  logic                  victim_sel;

  assign cpu_set    = addr[OFF_BITS +: SET_BITS];
  assign refill_set = base_q[OFF_BITS +: SET_BITS];
  // An empty way is always preferred; LRU only decides between two valid ways.
  assign victim_sel = !way_valid[0] ? 1'b0 :
                      !way_valid[1] ? 1'b1 : lru_q[cpu_set];

  assign refill_way = victim_q;
  assign hit_count  = hit_count_q;
  assign miss_count = miss_count_q;

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path leaves one unassigned and a latch cannot be inferred.
    state_d      = state_q;
    beat_d       = beat_q;
    base_d       = base_q;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    victim_d     = victim_q;
    lru_d        = lru_q;
    hit_count_d  = hit_count_q;
    miss_count_d = miss_count_q;
    stall        = 1'b0;
    cache_wr_en  = 1'b0;
    refill_en    = 1'b0;
    refill_word  = '0;
    refill_data  = '0;
    refill_last  = 1'b0;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr     = '0;
    mem_wdata    = '0;

    unique case (state_q)
      IDLE: begin
        if (write_en) begin
          stall       = 1'b1;
          cache_wr_en = hit;
          wr_addr_d   = addr & ~BYTE_MASK;
          wr_data_d   = write_data;
          state_d     = WRITE;
        end else if (read_en) begin
          if (hit) begin
            lru_d[cpu_set] = ~hit_way;
            hit_count_d    = hit_count_q + 32'd1;
          end else begin
            stall        = 1'b1;
            miss_count_d = miss_count_q + 32'd1;
            base_d       = addr & ~LINE_MASK;
            victim_d     = victim_sel;
            beat_d       = '0;
            state_d      = REFILL;
          end
        end
      end

      REFILL: begin
        stall    = 1'b1;
        mem_req  = 1'b1;
        mem_addr = base_q | ADDR_WIDTH'({beat_q, 2'b00});
        if (mem_ack) begin
          refill_en   = 1'b1;
          refill_word = beat_q;
          refill_data = mem_rdata;
          if (beat_q == LAST_BEAT) begin
            refill_last       = 1'b1;
            lru_d[refill_set] = ~victim_q;
            beat_d            = '0;
            state_d           = IDLE;
          end else begin
            beat_d = beat_q + WORD_BITS'(1);
          end
        end
      end

      WRITE: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = wr_addr_q;
        mem_wdata = wr_data_q;
        // Releasing the stall in the ack cycle lets the CPU advance without a bubble.
        stall     = ~mem_ack;
        if (mem_ack) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: state flops use non-blocking assignments so every register samples its pre-edge value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      beat_q       <= '0;
      base_q       <= '0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      victim_q     <= 1'b0;
      // NOTE: the LRU bits are a small flop vector, not a RAM, so they are cleared with the rest of the state.
      lru_q        <= '0;
      hit_count_q  <= '0;
      miss_count_q <= '0;
    end else begin
      state_q      <= state_d;
      beat_q       <= beat_d;
      base_q       <= base_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      victim_q     <= victim_d;
      lru_q        <= lru_d;
      hit_count_q  <= hit_count_d;
      miss_count_q <= miss_count_d;
    end
  end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Self-checking bench for dcache_ctrl: models the tag arrays, LRU policy, counters and a
// variable-latency memory, and checks every cycle of directed and random CPU transactions.
module tb_dcache_ctrl;

  logic        clk;
  logic        rst;
  logic        read_en;
  logic        write_en;
  logic [31:0] addr;
  logic [31:0] write_data;
  logic        hit;
  logic        hit_way;
  logic [1:0]  way_valid;
  logic        stall;
  logic        cache_wr_en;
  logic        refill_en;
  logic        refill_way;
  logic [0:0]  refill_word;
  logic [31:0] refill_data;
  logic        refill_last;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic [31:0] hit_count;
  logic [31:0] miss_count;

  dcache_ctrl dut (
    .clk(clk), .rst(rst), .read_en(read_en), .write_en(write_en), .addr(addr),
    .write_data(write_data), .hit(hit), .hit_way(hit_way), .way_valid(way_valid),
    .stall(stall), .cache_wr_en(cache_wr_en), .refill_en(refill_en),
    .refill_way(refill_way), .refill_word(refill_word), .refill_data(refill_data),
    .refill_last(refill_last), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int n_checks = 0;
  int n_errors = 0;

  // Reference state: tag arrays, LRU bits, counters, backing memory.
  bit          m_valid [16][2];
  logic [24:0] m_tag   [16][2];
  bit          m_lru   [16];
  int unsigned m_hits;
  int unsigned m_misses;
  logic [31:0] mem_model [logic [31:0]];
  int          mem_lat;
  int          lat_left;

  // Per-cycle samples of the DUT outputs.
  logic        s_stall, s_cwe, s_ren, s_rlast, s_rway, s_mreq, s_mwe, s_ack;
  logic [0:0]  s_rword;
  logic [31:0] s_rdata, s_maddr, s_mwdata, s_hc, s_mc;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic int set_of(input logic [31:0] a);
    return int'(a[6:3]);
  endfunction

  function automatic logic [24:0] tag_of(input logic [31:0] a);
    return a[31:7];
  endfunction

  function automatic logic [31:0] mem_read(input logic [31:0] a);
    if (mem_model.exists(a)) return mem_model[a];
    return (a * 32'h9E37_79B9) ^ 32'h5A5A_0000;
  endfunction

  function automatic bit model_hit(input logic [31:0] a);
    int s;
    s = set_of(a);
    for (int w = 0; w < 2; w++)
      if (m_valid[s][w] && m_tag[s][w] == tag_of(a)) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit model_way(input logic [31:0] a);
    int s;
    s = set_of(a);
    return (m_valid[s][1] && m_tag[s][1] == tag_of(a));
  endfunction

  // Drive the array lookup and memory response for this cycle, then sample outputs.
  task automatic step();
    int s;
    s         = set_of(addr);
    hit       = model_hit(addr);
    hit_way   = hit ? model_way(addr) : 1'($urandom);
    way_valid = {m_valid[s][1], m_valid[s][0]};
    mem_ack   = 1'b0;
    mem_rdata = $urandom;
    if (mem_req) begin
      if (lat_left == 0) begin
        mem_ack = 1'b1;
        if (!mem_we) mem_rdata = mem_read(mem_addr);
      end else begin
        lat_left--;
      end
    end else if ($urandom_range(0, 3) == 0) begin
      mem_ack = 1'b1;
    end
    #1;
    s_stall = stall;     s_cwe   = cache_wr_en; s_ren    = refill_en;
    s_rlast = refill_last; s_rway = refill_way; s_rword  = refill_word;
    s_rdata = refill_data; s_mreq = mem_req;    s_mwe    = mem_we;
    s_maddr = mem_addr;  s_mwdata = mem_wdata;  s_ack    = mem_ack;
    s_hc    = hit_count; s_mc    = miss_count;
  endtask

  // Advance one clock and apply what the arrays and memory would have done on that edge.
  task automatic tick();
    int s;
    @(posedge clk);
    #1;
    s = set_of(addr);
    if (s_ack && s_mreq) lat_left = mem_lat;
    if (s_rlast) begin
      m_valid[s][s_rway] = 1'b1;
      m_tag[s][s_rway]   = tag_of(addr);
    end
    if (s_ack && s_mreq && s_mwe) mem_model[s_maddr] = s_mwdata;
    mem_ack = 1'b0;
  endtask

  task automatic idle_check(input string tag);
    read_en  = 1'b0;
    write_en = 1'b0;
    step();
    check({tag, "_stall"}, s_stall, 0);
    check({tag, "_mem_req"}, s_mreq, 0);
    check({tag, "_hit_count"}, s_hc, m_hits);
    check({tag, "_miss_count"}, s_mc, m_misses);
    tick();
  endtask

  task automatic do_read(input logic [31:0] a, input int lat);
    int          s, beat, stalls, guard;
    bit          exp_hit, victim, hw;
    logic [31:0] base;
    mem_lat    = lat;
    lat_left   = lat;
    addr       = a;
    read_en    = 1'b1;
    write_en   = 1'b0;
    write_data = $urandom;
    s       = set_of(a);
    base    = a & ~32'h7;
    exp_hit = model_hit(a);
    victim  = !m_valid[s][0] ? 1'b0 : !m_valid[s][1] ? 1'b1 : m_lru[s];
    beat    = 0;
    stalls  = 0;
    guard   = 0;
    forever begin
      step();
      check("rd_cache_wr_en", s_cwe, 0);
      check("rd_refill_en", s_ren, s_ack & s_mreq & ~s_mwe);
      if (s_mreq) begin
        check("rd_mem_we", s_mwe, 0);
        check("rd_mem_addr", s_maddr, base + 32'(4 * beat));
      end
      if (s_ren) begin
        check("rd_refill_way", s_rway, victim);
        check("rd_refill_word", s_rword, beat);
        check("rd_refill_data", s_rdata, mem_read(base + 32'(4 * beat)));
        check("rd_refill_last", s_rlast, beat == 1);
        beat++;
      end
      if (!s_stall) break;
      stalls++;
      guard++;
      if (guard > 200) begin
        check("rd_timeout", guard, 0);
        break;
      end
      tick();
    end
    check("rd_stall_cycles", stalls, exp_hit ? 0 : 1 + 2 * (lat + 1));
    check("rd_beats", beat, exp_hit ? 0 : 2);
    tick();
    if (!exp_hit) begin
      m_misses++;
      m_lru[s] = ~victim;
    end
    check("rd_replay_hit", model_hit(a), 1);
    hw = model_way(a);
    m_hits++;
    m_lru[s] = ~hw;
    idle_check("rd_idle");
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input int lat,
                          input bit both);
    int cyc, stalls;
    bit exp_hit;
    mem_lat    = lat;
    lat_left   = lat;
    addr       = a;
    write_data = d;
    write_en   = 1'b1;
    read_en    = both;
    exp_hit    = model_hit(a);
    cyc        = 0;
    stalls     = 0;
    forever begin
      step();
      check("wr_cache_wr_en", s_cwe, (cyc == 0) ? exp_hit : 1'b0);
      check("wr_refill_en", s_ren, 0);
      if (s_mreq) begin
        check("wr_mem_we", s_mwe, 1);
        check("wr_mem_addr", s_maddr, a & ~32'h3);
        check("wr_mem_wdata", s_mwdata, d);
      end
      if (!s_stall) break;
      stalls++;
      cyc++;
      if (cyc > 200) begin
        check("wr_timeout", cyc, 0);
        break;
      end
      tick();
    end
    check("wr_stall_cycles", stalls, 1 + lat);
    check("wr_ack_on_release", s_ack & s_mreq, 1);
    tick();
    idle_check("wr_idle");
  endtask

  initial begin
    logic [31:0] a;
    rst        = 1'b1;
    read_en    = 1'b0;
    write_en   = 1'b0;
    addr       = '0;
    write_data = '0;
    hit        = 1'b0;
    hit_way    = 1'b0;
    way_valid  = 2'b00;
    mem_ack    = 1'b0;
    mem_rdata  = '0;
    m_hits     = 0;
    m_misses   = 0;
    mem_lat    = 0;
    lat_left   = 0;
    for (int s = 0; s < 16; s++) begin
      m_lru[s] = 1'b0;
      for (int w = 0; w < 2; w++) begin
        m_valid[s][w] = 1'b0;
        m_tag[s][w]   = '0;
      end
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state.
    step();
    check("rst_stall", s_stall, 0);
    check("rst_mem_req", s_mreq, 0);
    check("rst_mem_addr", s_maddr, 0);
    check("rst_refill_en", s_ren, 0);
    check("rst_cache_wr_en", s_cwe, 0);
    check("rst_hit_count", s_hc, 0);
    check("rst_miss_count", s_mc, 0);
    tick();

    // Reset in the middle of a refill, followed by a late ack.
    addr    = 32'h300;
    read_en = 1'b1;
    step();
    tick();
    step();
    check("abort_beat0_refill", s_ren, 1);
    check("abort_miss_before", s_mc, 1);
    tick();
    read_en = 1'b0;
    rst     = 1'b1;
    #1;
    mem_ack   = 1'b1;
    mem_rdata = 32'hDEAD_BEEF;
    #1;
    check("abort_mem_req", mem_req, 0);
    check("abort_refill_en", refill_en, 0);
    check("abort_refill_last", refill_last, 0);
    check("abort_stall", stall, 0);
    check("abort_hit_count", hit_count, 0);
    check("abort_miss_count", miss_count, 0);
    @(posedge clk);
    #1;
    mem_ack = 1'b0;
    rst     = 1'b0;
    lat_left = 0;
    idle_check("abort_idle");

    // Directed scenarios.
    mem_model[32'h100] = 32'h0000_AAAA;
    mem_model[32'h104] = 32'h0000_BBBB;
    do_read(32'h0000_0104, 0);
    check("cold_hit_count", hit_count, 1);
    check("cold_miss_count", miss_count, 1);
    do_read(32'h0000_1100, 0);
    do_read(32'h0000_0104, 0);
    check("full_set_lru", m_lru[0], 1);
    do_read(32'h0000_2100, 4);
    check("lru_after_slow_refill", m_valid[0][1] && m_tag[0][1] == tag_of(32'h2100), 1);
    do_read(32'h0000_0200, 0);
    do_write(32'h0000_0200, 32'h0000_1234, 2, 1'b0);
    do_write(32'h0000_5000, 32'h5555_0000, 1, 1'b0);
    do_write(32'h0000_7008, 32'h0000_CAFE, 0, 1'b1);

    // Randomized traffic over a small address pool so hits, misses and evictions all occur.
    for (int i = 0; i < 250; i++) begin
      a = (32'($urandom_range(0, 3)) << 7) | (32'($urandom_range(0, 3)) << 3) |
          (32'($urandom_range(0, 1)) << 2) | 32'($urandom_range(0, 3));
      if ($urandom_range(0, 9) < 6)
        do_read(a, $urandom_range(0, 3));
      else
        do_write(a, $urandom, $urandom_range(0, 3), $urandom_range(0, 3) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
